button_pio_ctrl: RTL and testbench

//  Multi-channel push-button PIO, Avalon-MM slave. Synchronises WIDTH async button inputs,

---
 rtl/button_pio_pkg.sv | 16 +
 rtl/button_debounce.sv | 60 ++++++
 rtl/button_pio_ctrl.sv | 96 +++++++++
 tb/tb_button_pio_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_pio_pkg.sv
// Shared constants and the slave request bundle for the push-button PIO.
package button_pio_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAPT = 2'd3;

  localparam int FALL_EN_LSB = 16;
  localparam int MAX_WIDTH   = 16;

  typedef struct packed {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } avl_req_t;
endpackage

// File: rtl/button_debounce.sv
// One button bit: 2-flop synchroniser, then an optional stability filter
// (enabled by defining BUTTON_PIO_DEBOUNCE_EN).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic level_o
);
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Any disagreement that lasts DEBOUNCE_CYCLES clocks is accepted; a bounce back
  // to the current level restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
`else
  // Unfiltered: level follows the synchroniser; DEBOUNCE_CYCLES has no effect.
  assign level_o = sync2_q & (DEBOUNCE_CYCLES >= 0);
`endif
endmodule

// File: rtl/button_pio_ctrl.sv
// Multi-channel push-button PIO (Avalon-MM slave): edge capture with W1C and level IRQ.
// Define BUTTON_PIO_DEBOUNCE_EN to insert the per-channel debounce filter.
module button_pio_ctrl
  import button_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  avl_req_t req;
  logic [WIDTH-1:0] level, edge_det, capt_clr;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] capt_q, capt_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             unused_wdata;

  assign req = '{we: chipselect & ~write_n, addr: address, wdata: writedata};
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (in_port[i]),
      .level_o (level[i])
    );
  end

  assign edge_det = (rise_en_q & level & ~prev_q) | (fall_en_q & ~level & prev_q);

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask_d    = mask_q;
    capt_clr  = '0;
    if (req.we) begin
      case (req.addr)
        ADDR_EDGE: begin
          rise_en_d = req.wdata[WIDTH-1:0];
          fall_en_d = req.wdata[FALL_EN_LSB +: WIDTH];
        end
        ADDR_MASK: mask_d   = req.wdata[WIDTH-1:0];
        ADDR_CAPT: capt_clr = req.wdata[WIDTH-1:0];
        default: ;
      endcase
    end
    // A new edge wins over a clear landing in the same cycle.
    capt_d = (capt_q & ~capt_clr) | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = level;
      ADDR_EDGE: begin
        readdata_d[WIDTH-1:0]              = rise_en_q;
        readdata_d[FALL_EN_LSB +: WIDTH]   = fall_en_q;
      end
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      default:   readdata_d[WIDTH-1:0] = capt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '1;
      mask_q     <= '0;
      capt_q     <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= level;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      mask_q     <= mask_d;
      capt_q     <= capt_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(capt_q & mask_q);
endmodule

// File: tb/tb_button_pio_ctrl.sv
// Directed bench for button_pio_ctrl: register table plus timing corner sequences.
module tb_button_pio_ctrl;
`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int DBC = 8;
`else
  localparam int DBC = 50000;
`endif
  localparam logic [1:0] A_DATA = 2'd0, A_EDGE = 2'd1, A_MASK = 2'd2, A_CAPT = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  in_port = 4'hF;
  logic        irq;

  int nchk = 0;
  int nerr = 0;

  button_pio_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(DBC)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic        cs;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  pins;
    int          waitc;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic do_reset(input logic [3:0] pins);
    in_port = pins;
    reset_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t vt[21];
  logic [31:0] r;

  initial begin
    // do_wr cs waddr wdata pins wait raddr exp_rd exp_irq
    vt[0]  = '{1'b0, 1'b0, A_DATA, 32'h0,         4'hF, 0, A_EDGE, 32'h000F_0000, 1'b0};
    vt[1]  = '{1'b0, 1'b0, A_DATA, 32'h0,         4'hF, 0, A_MASK, 32'h0,         1'b0};
    vt[2]  = '{1'b0, 1'b0, A_DATA, 32'h0,         4'hF, 0, A_CAPT, 32'h0,         1'b0};
    vt[3]  = '{1'b1, 1'b1, A_MASK, 32'h1,         4'hF, 0, A_MASK, 32'h1,         1'b0};
    vt[4]  = '{1'b0, 1'b0, A_DATA, 32'h0,         4'hE, 4, A_CAPT, 32'h1,         1'b1};
    vt[5]  = '{1'b0, 1'b0, A_DATA, 32'h0,         4'hE, 0, A_DATA, 32'hE,         1'b1};
    vt[6]  = '{1'b1, 1'b1, A_CAPT, 32'h1,         4'hE, 0, A_CAPT, 32'h0,         1'b0};
    vt[7]  = '{1'b1, 1'b1, A_EDGE, 32'h0001_0001, 4'hE, 0, A_EDGE, 32'h0001_0001, 1'b0};
    vt[8]  = '{1'b0, 1'b0, A_DATA, 32'h0,         4'hF, 4, A_CAPT, 32'h1,         1'b1};
    vt[9]  = '{1'b1, 1'b1, A_CAPT, 32'h1,         4'hF, 0, A_CAPT, 32'h0,         1'b0};
    vt[10] = '{1'b0, 1'b0, A_DATA, 32'h0,         4'hE, 4, A_CAPT, 32'h1,         1'b1};
    vt[11] = '{1'b1, 1'b1, A_CAPT, 32'hF,         4'hE, 0, A_CAPT, 32'h0,         1'b0};
    vt[12] = '{1'b1, 1'b1, A_EDGE, 32'h000F_0000, 4'hE, 0, A_EDGE, 32'h000F_0000, 1'b0};
    vt[13] = '{1'b1, 1'b1, A_MASK, 32'hFFFF_FFF0, 4'hE, 0, A_MASK, 32'h0,         1'b0};
    vt[14] = '{1'b0, 1'b0, A_DATA, 32'h0,         4'hA, 4, A_CAPT, 32'h4,         1'b0};
    vt[15] = '{1'b1, 1'b0, A_MASK, 32'h4,         4'hA, 0, A_MASK, 32'h0,         1'b0};
    vt[16] = '{1'b1, 1'b1, A_MASK, 32'h4,         4'hA, 0, A_CAPT, 32'h4,         1'b1};
    vt[17] = '{1'b1, 1'b1, A_DATA, 32'h5,         4'hA, 0, A_DATA, 32'hA,         1'b1};
    vt[18] = '{1'b1, 1'b1, A_CAPT, 32'h0,         4'hA, 0, A_CAPT, 32'h4,         1'b1};
    vt[19] = '{1'b1, 1'b1, A_CAPT, 32'hB,         4'hA, 0, A_CAPT, 32'h4,         1'b1};
    vt[20] = '{1'b1, 1'b1, A_MASK, 32'h1,         4'hA, 0, A_CAPT, 32'h4,         1'b0};

    do_reset(4'hF);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);

`ifndef BUTTON_PIO_DEBOUNCE_EN
    // DATA read shows the pins only after 2 sync clocks plus the read register
    address = A_DATA;
    tick(); tick();
    check("data_lat2", readdata, 32'h0);
    tick();
    check("data_lat3", readdata, 32'hF);
    tick();

    foreach (vt[k]) begin
      if (vt[k].do_wr) begin
        address = vt[k].waddr; writedata = vt[k].wdata;
        chipselect = vt[k].cs; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
      end
      in_port = vt[k].pins;
      repeat (vt[k].waitc) tick();
      rd(vt[k].raddr, r);
      check($sformatf("vec%0d_rd", k), r, vt[k].exp_rd);
      check($sformatf("vec%0d_irq", k), {31'b0, irq}, {31'b0, vt[k].exp_irq});
    end

    // Unmasking an already-captured bit raises irq on the following edge
    address = A_MASK; writedata = 32'h5; chipselect = 1'b1; write_n = 1'b0;
    check("unmask_before", {31'b0, irq}, 32'h0);
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    check("unmask_after", {31'b0, irq}, 32'h1);

    wr(A_CAPT, 32'hF);
    wr(A_MASK, 32'h1);
    wr(A_EDGE, 32'h0001_0001);

    // Pin change to capture: exactly 3 clocks
    in_port = 4'hB;
    tick(); tick();
    check("cap_lat2", {31'b0, irq}, 32'h0);
    tick();
    check("cap_lat3", {31'b0, irq}, 32'h1);

    // W1C colliding with a new edge on the same bit: bit stays set
    in_port = 4'hA;
    tick(); tick();
    address = A_CAPT; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    check("w1c_collide_irq", {31'b0, irq}, 32'h1);
    rd(A_CAPT, r);
    check("w1c_collide_capt", r, 32'h1);
    wr(A_CAPT, 32'h1);
    check("w1c_alone_irq", {31'b0, irq}, 32'h0);

    // Fill the capture register then reset mid-operation
    wr(A_EDGE, 32'h000F_000F);
    wr(A_MASK, 32'hF);
    in_port = 4'h5;
    repeat (4) tick();
    rd(A_CAPT, r);
    check("pre_reset_capt", r, 32'hF);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_irq", {31'b0, irq}, 32'h0);
    check("mid_reset_rd", readdata, 32'h0);
    in_port = 4'h0;
    tick(); tick();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();
    rd(A_CAPT, r);  check("post_reset_capt", r, 32'h0);
    rd(A_EDGE, r);  check("post_reset_edge", r, 32'h000F_0000);
    rd(A_MASK, r);  check("post_reset_mask", r, 32'h0);
    rd(A_DATA, r);  check("post_reset_data", r, 32'h0);
    check("post_reset_irq", {31'b0, irq}, 32'h0);
`else
    repeat (20) tick();
    wr(A_MASK, 32'h2);
    rd(A_DATA, r);
    check("db_settle_data", r, 32'hF);

    // A 5-clock glitch is filtered out
    in_port = 4'hD;
    repeat (5) tick();
    in_port = 4'hF;
    repeat (15) tick();
    rd(A_CAPT, r);  check("db_glitch_capt", r, 32'h0);
    rd(A_DATA, r);  check("db_glitch_data", r, 32'hF);

    // 12-clock press: sync falls at clk 2, filtered level at clk 10, capture at clk 11
    address = A_DATA;
    in_port = 4'hD;
    repeat (10) tick();
    check("db_irq_before", {31'b0, irq}, 32'h0);
    check("db_data_before", readdata, 32'hF);
    tick();
    check("db_irq_at", {31'b0, irq}, 32'h1);
    check("db_data_at", readdata, 32'hD);
    tick();
    in_port = 4'hF;
    rd(A_CAPT, r);  check("db_capt", r, 32'h2);

    // Reset in the middle of a count
    in_port = 4'hD;
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("db_reset_irq", {31'b0, irq}, 32'h0);
    check("db_reset_rd", readdata, 32'h0);
    in_port = 4'h0;
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) tick();
    rd(A_CAPT, r);  check("db_post_reset_capt", r, 32'h0);
    rd(A_EDGE, r);  check("db_post_reset_edge", r, 32'h000F_0000);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
